// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Brief    : Shared constants and state encoding for the fetch stage.
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // addi x0, x0, 0 : canonical RISC-V no-op used for pipeline bubbles
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Sequential fetch advances by one 32-bit instruction
    localparam int unsigned PC_STEP = 4;

    // IDLE: nothing outstanding, WAIT: response wanted, DROP: response discarded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_if
//  Brief    : Request/response bus between the fetch stage and instruction
//             memory. Single outstanding request, in-order responses.
//  Revision : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    // Fetch side drives the request, memory answers
    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_buffer
//  Brief    : One-entry pc/instruction holding register. Catches a response
//             that arrives while IF/ID is held; clear beats load beats drain.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            i_load,
    input  wire logic [XLEN-1:0] i_pc,
    input  wire logic [XLEN-1:0] i_instr,
    input  wire logic            i_drain,
    input  wire logic            i_clear,
    output logic                 o_valid,
    output logic [XLEN-1:0]      o_pc,
    output logic [XLEN-1:0]      o_instr
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;

    // Hold one entry; a redirect flush wins over a simultaneous load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= XLEN'(NOP_INSTR);
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch
//  Brief    : IF stage. Owns the fetch PC, issues single-outstanding
//             instruction memory requests and loads the IF/ID register,
//             honouring hazard-unit stalls and EX-stage redirects.
//  Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  wire logic              i_clk,
    input  wire logic              i_reset,
    input  wire logic              i_pc_enable,
    input  wire logic              i_if_id_register_enable,
    input  wire logic              i_redirect,
    input  wire logic [XLEN-1:0]   i_redirect_pc,
    instruction_fetch_if.master    imem,
    output logic [XLEN-1:0]        o_id_pc,
    output logic [XLEN-1:0]        o_id_instr,
    output logic                   o_id_valid
);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic [XLEN-1:0] r_id_pc;
    logic [XLEN-1:0] r_id_instr;
    logic            r_id_valid;

    logic            w_buf_valid;
    logic [XLEN-1:0] w_buf_pc;
    logic [XLEN-1:0] w_buf_instr;
    logic            w_slot_free;
    logic            w_accept;
    logic            w_rsp;
    logic [XLEN-1:0] w_redirect_target;

    // Targets are word aligned; low two bits of the redirect are ignored
    assign w_redirect_target = i_redirect_pc & ~XLEN'(3);

    // A new request may go out when idle, or when the current response
    // retires into IF/ID in this very cycle (back-to-back streaming)
    assign w_slot_free = (r_state == IDLE) ||
                         ((r_state == WAIT) && imem.rvalid && i_if_id_register_enable);

    assign imem.req  = !i_reset && !i_redirect && i_pc_enable && !w_buf_valid && w_slot_free;
    assign imem.addr = r_pc;
    assign w_accept  = imem.req && imem.gnt;

    // Response belonging to a request whose data is still wanted
    assign w_rsp = (r_state == WAIT) && imem.rvalid;

    fetch_buffer #(
        .XLEN (XLEN)
    ) u_fetch_buffer (
        .clk     (i_clk),
        .rst     (i_reset),
        .i_load  (w_rsp && !i_redirect && !i_if_id_register_enable),
        .i_pc    (r_req_pc),
        .i_instr (imem.rdata),
        .i_drain (!i_redirect && i_if_id_register_enable && w_buf_valid),
        .i_clear (i_redirect),
        .o_valid (w_buf_valid),
        .o_pc    (w_buf_pc),
        .o_instr (w_buf_instr)
    );

    // PC, request tracking FSM and IF/ID register; redirect overrides stall
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_id_pc    <= '0;
            r_id_instr <= XLEN'(NOP_INSTR);
            r_id_valid <= 1'b0;
        end else if (i_redirect) begin
            r_pc       <= w_redirect_target;
            r_id_instr <= XLEN'(NOP_INSTR);
            r_id_valid <= 1'b0;
            case (r_state)
                WAIT:    r_state <= imem.rvalid ? IDLE : DROP;
                DROP:    r_state <= imem.rvalid ? IDLE : DROP;
                default: r_state <= IDLE;
            endcase
        end else begin
            if (w_accept) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + XLEN'(PC_STEP);
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) r_state <= WAIT;
                end
                WAIT: begin
                    if (imem.rvalid) r_state <= w_accept ? WAIT : IDLE;
                end
                DROP: begin
                    if (imem.rvalid) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            // Buffered instruction is older than a live response, so it goes first
            if (i_if_id_register_enable) begin
                if (w_buf_valid) begin
                    r_id_pc    <= w_buf_pc;
                    r_id_instr <= w_buf_instr;
                    r_id_valid <= 1'b1;
                end else if (w_rsp) begin
                    r_id_pc    <= r_req_pc;
                    r_id_instr <= imem.rdata;
                    r_id_valid <= 1'b1;
                end else begin
                    r_id_instr <= XLEN'(NOP_INSTR);
                    r_id_valid <= 1'b0;
                end
            end
        end
    end

    assign o_id_pc    = r_id_pc;
    assign o_id_instr = r_id_instr;
    assign o_id_valid = r_id_valid;

    // Memory must never answer when no request is outstanding
    a_no_rsp_when_idle : assert property (
        @(posedge i_clk) disable iff (i_reset) !((r_state == IDLE) && imem.rvalid)
    );

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch
//  Brief    : Directed self-checking bench for instruction_fetch with a
//             variable-latency single-outstanding memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;
    import fetch_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            pc_en;
    logic            ifid_en;
    logic            redir;
    logic [XLEN-1:0] redir_pc;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_instr;
    logic            id_valid;

    int n_checks = 0;
    int n_pass   = 0;

    // Memory model state
    bit              pend = 1'b0;
    logic [XLEN-1:0] paddr = '0;
    int              cnt = 0;
    int              lat = 1;

    always #5 clk = ~clk;

    instruction_fetch_if #(.XLEN(XLEN)) bus ();

    instruction_fetch #(
        .XLEN     (XLEN),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .i_clk                   (clk),
        .i_reset                 (rst),
        .i_pc_enable             (pc_en),
        .i_if_id_register_enable (ifid_en),
        .i_redirect              (redir),
        .i_redirect_pc           (redir_pc),
        .imem                    (bus),
        .o_id_pc                 (id_pc),
        .o_id_instr              (id_instr),
        .o_id_valid              (id_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    endtask

    // One clock: sample the handshake mid-cycle, advance, then update memory
    task automatic tick();
        logic            acc;
        logic            rv_prev;
        logic            rst_prev;
        logic [XLEN-1:0] a;
        @(negedge clk);
        acc      = bus.req & bus.gnt;
        a        = bus.addr;
        rv_prev  = bus.rvalid;
        rst_prev = rst;
        @(posedge clk);
        #1;
        if (rst_prev) begin
            pend = 1'b0;
        end else begin
            if (rv_prev) pend = 1'b0;
            if (acc) begin
                pend  = 1'b1;
                paddr = a;
                cnt   = lat;
            end else if (pend) begin
                cnt--;
            end
        end
        bus.rvalid = pend && (cnt <= 1);
        bus.rdata  = (pend && (cnt <= 1)) ? (paddr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        redir      = 1'b0;
        redir_pc   = '0;
        bus.gnt    = 1'b1;
        bus.rvalid = 1'b0;
        bus.rdata  = '0;

        tick();
        tick();
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_instr", id_instr, 32'h0000_0013);
        check("rst_id_pc",    id_pc,    32'h0);
        check("rst_req",      32'(bus.req), 32'd0);

        // Streaming with 1-cycle memory
        rst = 1'b0;
        #1;
        check("first_req",  32'(bus.req), 32'd1);
        check("first_addr", bus.addr, 32'h0);
        tick();
        check("b2b_req",    32'(bus.req), 32'd1);
        check("b2b_addr4",  bus.addr, 32'h4);
        check("latency_valid_low", 32'(id_valid), 32'd0);
        tick();
        check("pc0_id_pc",    id_pc,    32'h0);
        check("pc0_id_instr", id_instr, 32'hA5A5_0000);
        check("pc0_id_valid", 32'(id_valid), 32'd1);
        check("b2b_addr8",    bus.addr, 32'h8);
        tick();
        check("pc4_id_pc",    id_pc,    32'h4);
        check("pc4_id_instr", id_instr, 32'hA5A5_0004);

        // Load-use stall while the pc-8 response returns
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        #1;
        check("stall_no_req", 32'(bus.req), 32'd0);
        tick();
        check("stall_hold_pc1", id_pc, 32'h4);
        check("stall_no_req2",  32'(bus.req), 32'd0);
        tick();
        check("stall_hold_pc2", id_pc, 32'h4);
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        #1;
        check("buf_blocks_req", 32'(bus.req), 32'd0);
        tick();
        check("release_id_pc",    id_pc,    32'h8);
        check("release_id_instr", id_instr, 32'hA5A5_0008);
        check("release_id_valid", 32'(id_valid), 32'd1);
        check("release_req",      32'(bus.req), 32'd1);
        check("release_addr12",   bus.addr, 32'hC);

        // Redirect with a 3-cycle response outstanding
        lat = 3;
        tick();
        check("bubble_valid", 32'(id_valid), 32'd0);
        check("bubble_pc",    id_pc, 32'h8);
        check("wait_no_req",  32'(bus.req), 32'd0);
        redir    = 1'b1;
        redir_pc = 32'h0000_0100;
        tick();
        redir = 1'b0;
        #1;
        check("drop_req",       32'(bus.req), 32'd0);
        check("drop_addr",      bus.addr, 32'h100);
        check("redir_id_valid", 32'(id_valid), 32'd0);
        check("redir_id_instr", id_instr, 32'h0000_0013);
        tick();
        check("drop_rsp_no_req", 32'(bus.req), 32'd0);
        tick();
        check("after_drop_req",   32'(bus.req), 32'd1);
        check("after_drop_addr",  bus.addr, 32'h100);
        check("stale_discarded",  32'(id_valid), 32'd0);

        // Redirect coinciding with rvalid and stall
        lat = 1;
        tick();
        check("addr_104", bus.addr, 32'h104);
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        redir    = 1'b1;
        redir_pc = 32'h0000_0203;
        #1;
        check("redir_blocks_req", 32'(bus.req), 32'd0);
        tick();
        redir   = 1'b0;
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        #1;
        check("redir2_id_valid", 32'(id_valid), 32'd0);
        check("redir2_id_instr", id_instr, 32'h0000_0013);
        check("redir2_req",      32'(bus.req), 32'd1);
        check("redir2_addr",     bus.addr, 32'h200);
        tick();
        check("redir2_rsp_discarded", 32'(id_valid), 32'd0);

        // Fill the buffer, then redirect to the top of the address space
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        tick();
        check("buf_fill_hold", 32'(id_valid), 32'd0);
        redir    = 1'b1;
        redir_pc = 32'hFFFF_FFFC;
        tick();
        redir   = 1'b0;
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        #1;
        check("buf_cleared_req", 32'(bus.req), 32'd1);
        check("wrap_addr_top",   bus.addr, 32'hFFFF_FFFC);
        tick();
        check("buf_cleared_no_instr", 32'(id_valid), 32'd0);
        check("wrap_addr_zero",       bus.addr, 32'h0);
        tick();
        check("wrap_id_pc",    id_pc,    32'hFFFF_FFFC);
        check("wrap_id_instr", id_instr, 32'h5A5A_FFFC);
        check("wrap_id_valid", 32'(id_valid), 32'd1);
        check("wrap_addr4",    bus.addr, 32'h4);

        // Reset with the buffer full
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        tick();
        check("pre_rst_hold", id_pc, 32'hFFFF_FFFC);
        rst = 1'b1;
        tick();
        check("mid_rst_id_valid", 32'(id_valid), 32'd0);
        check("mid_rst_id_instr", id_instr, 32'h0000_0013);
        check("mid_rst_id_pc",    id_pc, 32'h0);
        check("mid_rst_req",      32'(bus.req), 32'd0);
        rst     = 1'b0;
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        #1;
        check("post_rst_req",  32'(bus.req), 32'd1);
        check("post_rst_addr", bus.addr, 32'h0);
        tick();
        check("post_rst_buf_empty", 32'(id_valid), 32'd0);
        tick();
        check("post_rst_id_pc",    id_pc,    32'h0);
        check("post_rst_id_instr", id_instr, 32'hA5A5_0000);
        check("post_rst_id_valid", 32'(id_valid), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
